// File: rtl/counter_pkg.sv
// Shared types and constants for the counter datapath and its UART consumer.
package counter_pkg;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int COUNTER_WIDTH             = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. A write is accepted while full when a read
// happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  timeunit 1ns;
  timeprecision 100ps;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);

  // NOTE: the storage array has no reset; pointers and level alone define
  // which entries are valid, so resetting the data would only cost logic.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/value_uart_tx.sv
// Queues every change of the counter value and sends it as an 8N1 UART frame,
// LSB first. Changes arriving while the queue is full are dropped and flagged.
module value_uart_tx
  import counter_pkg::*;
#(
  parameter int WIDTH        = COUNTER_WIDTH,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              value,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);
  timeunit 1ns;
  timeprecision 100ps;

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(WIDTH);

  uart_state_t      state_q, state_n;
  logic [BW-1:0]    baud_q, baud_n;
  logic [IW-1:0]    bit_q, bit_n;
  logic [WIDTH-1:0] shift_q, shift_n;
  logic             tx_q, tx_n;
  logic [WIDTH-1:0] prev_q;
  logic             overflow_q;

  logic             push;
  logic             pop;
  logic             last_tick;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_full;
  logic             fifo_empty;

  assign push = (value != prev_q);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (value),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign last_tick = (baud_q == BW'(CLKS_PER_BIT - 1));

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    tx_n    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_data;
          state_n = START;
          tx_n    = 1'b0;
          baud_n  = '0;
        end
      end
      START: begin
        baud_n = baud_q + BW'(1);
        if (last_tick) begin
          state_n = DATA;
          tx_n    = shift_q[0];
          baud_n  = '0;
          bit_n   = '0;
        end
      end
      DATA: begin
        baud_n = baud_q + BW'(1);
        if (last_tick) begin
          baud_n = '0;
          if (bit_q == IW'(WIDTH - 1)) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            // The next bit to drive is the one about to land in shift[0].
            shift_n = shift_q >> 1;
            tx_n    = shift_q[1];
            bit_n   = bit_q + IW'(1);
          end
        end
      end
      STOP: begin
        baud_n = baud_q + BW'(1);
        if (last_tick) begin
          state_n = IDLE;
          baud_n  = '0;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      prev_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      tx_q    <= tx_n;
      prev_q  <= value;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;
endmodule

// File: tb/tb_value_uart_tx.sv
// Directed bench for value_uart_tx: a line monitor decodes frames and compares
// them against a queue of values expected to be sent.
module tb_value_uart_tx;
  timeunit 1ns;
  timeprecision 100ps;

  logic       clk;
  logic       reset;
  logic [7:0] value;
  logic       tx;
  logic       busy;
  logic [2:0] level;
  logic       overflow;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb[$];
  logic       rst_seen = 1'b0;
  logic       inc_mode = 1'b0;
  int         inc_frames = 0;

  value_uart_tx dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .tx       (tx),
    .busy     (busy),
    .level    (level),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  always @(negedge reset) rst_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy == 1'b0 && level == 3'd0 && sb.size() == 0) && n < 2000);
    check(tag, 32'(n < 2000), 32'd1);
  endtask

  // Line monitor: decodes frames starting on a falling edge of tx.
  initial begin
    logic       ptx;
    logic       start_bit;
    logic       stop_bit;
    logic [7:0] d;
    logic [7:0] last;
    logic [7:0] diff;
    logic [31:0] exp;
    ptx  = 1'b1;
    last = 8'd0;
    forever begin
      @(negedge clk);
      if (reset && ptx && !tx) begin
        rst_seen = 1'b0;
        repeat (2) @(negedge clk);
        start_bit = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          d[i] = tx;
        end
        repeat (4) @(negedge clk);
        stop_bit = tx;
        if (!rst_seen) begin
          check("start_bit", 32'(start_bit), 32'd0);
          check("stop_bit", 32'(stop_bit), 32'd1);
          if (inc_mode) begin
            diff = d - last;
            check("inc_order", 32'(diff != 8'd0 && diff < 8'd128), 32'd1);
            last = d;
            inc_frames++;
          end else begin
            exp = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'hDEAD;
            check("frame_data", 32'(d), exp);
          end
        end
      end
      ptx = tx;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    logic [7:0] fill[5];
    reset = 1'b1;
    value = 8'd0;
    #0.5 reset = 1'b0;

    // 1: outputs pinned at reset values while value toggles
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      value = 8'($urandom);
    end
    value = 8'd0;
    @(negedge clk);
    reset = 1'b1;

    // 2: single frame A5, latency and busy width
    @(negedge clk);
    value = 8'hA5;
    sb.push_back(8'hA5);
    @(negedge clk);
    check("t2_tx_pre", 32'(tx), 32'd1);
    check("t2_busy_pre", 32'(busy), 32'd0);
    check("t2_level_pre", 32'(level), 32'd1);
    @(negedge clk);
    check("t2_tx_start", 32'(tx), 32'd0);
    check("t2_level_pop", 32'(level), 32'd0);
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      else break;
    end
    check("t2_busy_cycles", 32'(busy_cnt), 32'd40);
    wait_idle("t2_drain");

    // 3: six changes back to back, sixth dropped
    @(negedge clk);
    value = 8'h11; sb.push_back(8'h11);
    @(negedge clk);
    value = 8'h22; sb.push_back(8'h22);
    @(negedge clk);
    value = 8'h33; sb.push_back(8'h33);
    @(negedge clk);
    value = 8'h44; sb.push_back(8'h44);
    @(negedge clk);
    value = 8'h55; sb.push_back(8'h55);
    @(negedge clk);
    check("t3_level_full", 32'(level), 32'd4);
    check("t3_ovf_before", 32'(overflow), 32'd0);
    value = 8'h66;
    @(negedge clk);
    check("t3_level_peak", 32'(level), 32'd4);
    check("t3_ovf_set", 32'(overflow), 32'd1);
    wait_idle("t3_drain");
    check("t3_ovf_sticky", 32'(overflow), 32'd1);

    // 4: push on the pop edge while full
    @(negedge clk);
    reset = 1'b0;
    value = 8'd0;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("t4_ovf_cleared", 32'(overflow), 32'd0);
    fill = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      value = fill[i];
      sb.push_back(fill[i]);
    end
    @(negedge clk);
    check("t4_level_full", 32'(level), 32'd4);
    busy_cnt = 0;
    while (busy && busy_cnt < 100) begin
      @(negedge clk);
      busy_cnt++;
    end
    check("t4_busy_fell", 32'(busy), 32'd0);
    value = 8'h0F;
    sb.push_back(8'h0F);
    @(negedge clk);
    check("t4_level_held", 32'(level), 32'd4);
    check("t4_ovf_clear", 32'(overflow), 32'd0);
    wait_idle("t4_drain");
    check("t4_ovf_end", 32'(overflow), 32'd0);

    // 5: reset mid-DATA abandons the frame immediately
    @(negedge clk);
    value = 8'h3C;
    repeat (12) @(negedge clk);
    check("t5_busy_mid", 32'(busy), 32'd1);
    #0.3 reset = 1'b0;
    value = 8'd0;
    #0.2;
    check("t5_async_tx", 32'(tx), 32'd1);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_level", 32'(level), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("t5_quiet", {30'd0, tx, busy}, 32'd2);
    end

    // 6: free-running counter source
    inc_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      value = value + 8'd1;
    end
    wait_idle("t6_drain");
    check("t6_ovf", 32'(overflow), 32'd1);
    check("t6_frames", 32'(inc_frames >= 6), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
